// File: rtl/sm_bin_to_bcd_seq_pkg.sv
// rtl/sm_bin_to_bcd_seq_pkg.sv - shared state encoding and digit constants for the BCD converter
package sm_bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/sm_bcd_digit_adj.sv
// rtl/sm_bcd_digit_adj.sv - one double-dabble digit correction: add 3 when the digit is 5 or more
module sm_bcd_digit_adj
  import sm_bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;

endmodule

// File: rtl/sm_bin_to_bcd_seq.sv
// rtl/sm_bin_to_bcd_seq.sv - sequential binary-to-BCD converter, one input bit per clock
// Produces BCD digits, a leading-zero blank mask and an overflow flag for the display glue.
module sm_bin_to_bcd_seq
  import sm_bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic [WIDTH-1:0]                bin,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]               blank,
  output logic                            ovf,
  output logic                            out_valid
);

  localparam int                WORK_W    = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  state_t            state, state_next;
  logic [WIDTH-1:0]  sreg, sreg_next;
  logic [WORK_W-1:0] work, work_next, work_adj, work_shift;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              sticky, sticky_next;
  logic              carry;
  logic [WORK_W-1:0] bcd_next;
  logic [DIGITS-1:0] blank_next, blank_calc;
  logic              ovf_next, out_valid_next;
  logic              all_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    sm_bcd_digit_adj u_adj (
      .digit    (work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Digits that fall off the top are lost, so the result is naturally bin mod 10^DIGITS.
  assign work_shift = {work_adj[WORK_W-2:0], sreg[WIDTH-1]};
  assign carry      = work_adj[WORK_W-1];

  always_comb begin
    blank_calc = '0;
    all_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero      = all_zero & (work_shift[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
      blank_calc[k] = all_zero;
    end
  end

  always_comb begin
    state_next     = state;
    sreg_next      = sreg;
    work_next      = work;
    cnt_next       = cnt;
    sticky_next    = sticky;
    bcd_next       = bcd;
    blank_next     = blank;
    ovf_next       = ovf;
    out_valid_next = 1'b0;
    in_ready       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_next   = bin;
          work_next   = '0;
          sticky_next = 1'b0;
          cnt_next    = '0;
          state_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_next   = sreg << 1;
        work_next   = work_shift;
        sticky_next = sticky | carry;
        cnt_next    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          bcd_next       = work_shift;
          ovf_next       = sticky | carry;
          blank_next     = blank_calc;
          out_valid_next = 1'b1;
          state_next     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      work      <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      bcd       <= '0;
      blank     <= BLANK_RST;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      sreg      <= sreg_next;
      work      <= work_next;
      cnt       <= cnt_next;
      sticky    <= sticky_next;
      bcd       <= bcd_next;
      blank     <= blank_next;
      ovf       <= ovf_next;
      out_valid <= out_valid_next;
    end
  end

endmodule
